// File: rtl/booth_div_pkg.sv
// Shared widths, state encoding and saturation limits for the booth_div signed divider.
package booth_div_pkg;

    localparam int DW = 41;
    localparam int VW = 16;
    localparam int QW = 25;
    localparam int CW = 6;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam logic signed [QW-1:0] QMAX = 25'sh0FF_FFFF;
    localparam logic signed [QW-1:0] QMIN = 25'sh100_0000;

endpackage

// File: rtl/booth_div_if.sv
// Operand and result handshakes of booth_div; master drives operands, slave is the divider.
interface booth_div_if;
    import booth_div_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] dividend;
    logic signed [VW-1:0] divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [QW-1:0] quotient;
    logic signed [VW-1:0] remainder;
    logic                 ovf;
    logic                 dz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, dz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, dz
    );

endinterface

// File: rtl/booth_div_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step
    import booth_div_pkg::*;
(
    input  logic [VW:0]   prem,
    input  logic          din,
    input  logic [VW-1:0] dvs,
    output logic [VW:0]   prem_nxt,
    output logic          qbit
);

    logic [VW+1:0] trial;

    always_comb begin
        trial    = {prem, din};
        qbit     = (trial >= {2'b00, dvs});
        prem_nxt = (VW+1)'(qbit ? trial - {2'b00, dvs} : trial);
    end

endmodule

// File: rtl/booth_div.sv
// Sequential signed divider, 41-bit dividend by 16-bit divisor, one quotient bit per cycle,
// with saturation of the 25-bit quotient and divide-by-zero flagging.
module booth_div
    import booth_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    booth_div_if.slave  bus
);

    localparam logic [DW-1:0] MAG_POS = DW'(24'hFF_FFFF);
    localparam logic [DW-1:0] MAG_NEG = DW'(25'h100_0000);

    state_t               state, state_nxt;
    logic                 accept;
    logic [CW-1:0]        cnt;
    logic [DW-1:0]        dvd;
    logic [VW-1:0]        dvs;
    logic [VW:0]          prem, prem_nxt;
    logic                 qbit;
    logic                 neg_d, neg_q;
    logic signed [QW-1:0] q_fix;
    logic signed [VW-1:0] r_fix;
    logic                 ovf_fix;

    div_step u_step (
        .prem     (prem),
        .din      (dvd[DW-1]),
        .dvs      (dvs),
        .prem_nxt (prem_nxt),
        .qbit     (qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.in_ready = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (bus.out_valid && bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // After the last step dvd holds the quotient magnitude: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_comb begin
        ovf_fix = 1'b0;
        q_fix   = neg_q ? -QW'(dvd) : QW'(dvd);
        r_fix   = neg_d ? -VW'(prem) : VW'(prem);
        if (dvs == '0) begin
            q_fix = neg_d ? QMIN : QMAX;
            r_fix = '0;
        end else if (!neg_q && dvd > MAG_POS) begin
            q_fix   = QMAX;
            ovf_fix = 1'b1;
        end else if (neg_q && dvd > MAG_NEG) begin
            q_fix   = QMIN;
            ovf_fix = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            dvd           <= '0;
            dvs           <= '0;
            prem          <= '0;
            neg_d         <= 1'b0;
            neg_q         <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.ovf       <= 1'b0;
            bus.dz        <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (accept) begin
                dvd   <= bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
                dvs   <= bus.divisor[VW-1] ? -bus.divisor : bus.divisor;
                neg_d <= bus.dividend[DW-1];
                neg_q <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
                prem  <= '0;
                cnt   <= CW'(DW-1);
            end
            if (state == CALC) begin
                prem <= prem_nxt;
                dvd  <= {dvd[DW-2:0], qbit};
                if (cnt != '0) cnt <= cnt - CW'(1);
            end
            if (state == FIX) begin
                bus.quotient  <= q_fix;
                bus.remainder <= r_fix;
                bus.ovf       <= ovf_fix;
                bus.dz        <= (dvs == '0);
            end
            // Results sit one cycle in DONE before being offered to the consumer.
            bus.out_valid <= (state == DONE) && !(bus.out_valid && bus.out_ready);
        end
    end

endmodule

// File: tb/tb_booth_div.sv
// Self-checking bench for booth_div: directed cases, handshake behaviour and randomized
// operands against an arithmetic reference model.
module tb_booth_div;
    import booth_div_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    booth_div_if bus ();

    booth_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic void model(input longint a, input longint b,
                                  output longint q, output longint r,
                                  output logic o, output logic z);
        o = 1'b0;
        if (b == 0) begin
            z = 1'b1;
            r = 0;
            q = (a >= 0) ? 16777215 : -16777216;
        end else begin
            z = 1'b0;
            q = a / b;
            r = a % b;
            if (q > 16777215) begin
                q = 16777215;
                o = 1'b1;
            end else if (q < -16777216) begin
                q = -16777216;
                o = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input longint a, input longint b,
                           output longint q, output longint r,
                           output logic o, output logic z, output int lat);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        bus.dividend = 41'(a);
        bus.divisor  = 16'(b);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        q = bus.quotient;
        r = bus.remainder;
        o = bus.ovf;
        z = bus.dz;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.quotient !== '0 || bus.remainder !== '0 || bus.ovf !== 1'b0 || bus.dz !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: q=%0d r=%0d ovf=%b dz=%b, required all zero",
                     bus.quotient, bus.remainder, bus.ovf, bus.dz);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        longint q, r;
        logic   o, z;
        int     lat;
        run_div(1000, 7, q, r, o, z, lat);
        checks++;
        if (q !== 142 || r !== 6 || o !== 1'b0 || z !== 1'b0) begin
            failures++;
            $display("FAIL basic_1000_7: q=%0d r=%0d ovf=%b dz=%b, required 142 6 0 0", q, r, o, z);
        end
        checks++;
        if (lat !== 43) begin
            failures++;
            $display("FAIL basic_latency: %0d cycles, required 43", lat);
        end
    endtask

    task automatic test_signs();
        longint ta[3] = '{-1000, 1000, -1000};
        longint tb[3] = '{7, -7, -7};
        longint eq[3] = '{-142, -142, 142};
        longint er[3] = '{-6, 6, -6};
        longint q, r;
        logic   o, z;
        int     lat;
        for (int i = 0; i < 3; i++) begin
            run_div(ta[i], tb[i], q, r, o, z, lat);
            checks++;
            if (q !== eq[i] || r !== er[i] || o !== 1'b0 || z !== 1'b0) begin
                failures++;
                $display("FAIL signs_%0d_%0d: q=%0d r=%0d ovf=%b dz=%b, required %0d %0d 0 0",
                         ta[i], tb[i], q, r, o, z, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_saturation();
        longint ta[3] = '{longint'(1) <<< 39, -(longint'(1) <<< 40), -(longint'(1) <<< 24)};
        longint tb[3] = '{1, -1, 1};
        longint eq[3] = '{16777215, 16777215, -16777216};
        logic   eo[3] = '{1'b1, 1'b1, 1'b0};
        longint q, r;
        logic   o, z;
        int     lat;
        for (int i = 0; i < 3; i++) begin
            run_div(ta[i], tb[i], q, r, o, z, lat);
            checks++;
            if (q !== eq[i] || r !== 0 || o !== eo[i] || z !== 1'b0) begin
                failures++;
                $display("FAIL saturation_%0d: q=%0d r=%0d ovf=%b dz=%b, required %0d 0 %b 0",
                         i, q, r, o, z, eq[i], eo[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        longint ta[2] = '{12345, -5};
        longint eq[2] = '{16777215, -16777216};
        longint q, r;
        logic   o, z;
        int     lat;
        for (int i = 0; i < 2; i++) begin
            run_div(ta[i], 0, q, r, o, z, lat);
            checks++;
            if (q !== eq[i] || r !== 0 || o !== 1'b0 || z !== 1'b1) begin
                failures++;
                $display("FAIL div_zero_%0d: q=%0d r=%0d ovf=%b dz=%b, required %0d 0 0 1",
                         ta[i], q, r, o, z, eq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [QW+VW+1:0] snap;
        longint q, r;
        logic   o, z;
        int     n = 0;
        int     lat;
        bus.dividend = 41'(1000);
        bus.divisor  = 16'(7);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        snap = {bus.quotient, bus.remainder, bus.ovf, bus.dz};
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({bus.quotient, bus.remainder, bus.ovf, bus.dz} !== snap || bus.out_valid !== 1'b1
                || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold_%0d: q=%0d r=%0d out_valid=%b in_ready=%b, required 142 6 1 0",
                         i, bus.quotient, bus.remainder, bus.out_valid, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
        run_div(2000, -9, q, r, o, z, lat);
        checks++;
        if (q !== -222 || r !== 2 || lat !== 43) begin
            failures++;
            $display("FAIL back_to_back: q=%0d r=%0d lat=%0d, required -222 2 43", q, r, lat);
        end
    endtask

    task automatic test_ignore_busy();
        int n = 0;
        bus.dividend = -41'sd1000;
        bus.divisor  = 16'sd7;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.in_valid = (i >= 3);
            bus.dividend = 41'($urandom);
            bus.divisor  = 16'($urandom_range(1, 100));
            tick();
            n++;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL busy_in_ready_%0d: in_ready=%b, required 0", i, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (bus.quotient !== -25'sd142 || bus.remainder !== -16'sd6 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL busy_operands_ignored: q=%0d r=%0d out_valid=%b, required -142 -6 1",
                     bus.quotient, bus.remainder, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        longint q, r;
        logic   o, z;
        int     lat;
        bus.dividend = 41'(1000);
        bus.divisor  = 16'(7);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== '0
            || bus.remainder !== '0 || bus.ovf !== 1'b0 || bus.dz !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b q=%0d r=%0d, required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder);
        end
        run_div(100, -3, q, r, o, z, lat);
        checks++;
        if (q !== -33 || r !== 1 || o !== 1'b0 || z !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_100_m3: q=%0d r=%0d, required -33 1", q, r);
        end
    endtask

    task automatic test_random();
        logic signed [DW-1:0] ta;
        logic signed [VW-1:0] tb16;
        longint a, b, q, r, eq, er;
        logic   o, z, eo, ez;
        int     lat;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0: begin ta = DW'({$urandom(), $urandom()}); a = ta; end
                1: a = (longint'(1) <<< 40) - 1 - longint'($urandom_range(0, 1000));
                2: a = -(longint'(1) <<< 40) + longint'($urandom_range(0, 1000));
                3: a = longint'($urandom_range(0, 200000)) - 100000;
                default: a = longint'($urandom_range(0, 1 << 30)) - (1 << 29);
            endcase
            case ($urandom_range(0, 9))
                0, 1: b = -32768;
                2: b = 32767;
                3: b = ($urandom_range(0, 3) == 0) ? 0 : 1;
                4, 5: b = longint'($urandom_range(1, 40)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
                default: begin tb16 = VW'($urandom); b = tb16; end
            endcase
            model(a, b, eq, er, eo, ez);
            run_div(a, b, q, r, o, z, lat);
            checks++;
            if (q !== eq || r !== er || o !== eo || z !== ez || lat !== 43) begin
                failures++;
                $display("FAIL random_%0d: %0d/%0d gave q=%0d r=%0d ovf=%b dz=%b lat=%0d, required %0d %0d %b %b 43",
                         i, a, b, q, r, o, z, lat, eq, er, eo, ez);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        test_reset();
        test_basic();
        test_signs();
        test_saturation();
        test_div_zero();
        test_backpressure();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
